// File: rtl/subbytes_sched.sv
// Shared 32-bit SubBytes engine with four S-box lanes, time-multiplexed between
// a 128-bit cipher-state requester and a 32-bit key-word (SubWord) requester.
module subbytes_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         stValid,
  input  logic [127:0] stIn,
  output logic         stReady,
  output logic         stOutValid,
  output logic [127:0] stOut,
  input  logic         kwValid,
  input  logic [31:0]  kwIn,
  output logic         kwReady,
  output logic         kwOutValid,
  output logic [31:0]  kwOut
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned LANES   = 4;

  localparam logic OWN_ST = 1'b0;
  localparam logic OWN_KW = 1'b1;

  // AES forward S-box, entry 0 first.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [STATE_W-1:0]  work;
  logic [STATE_W-1:0]  work_wb;
  logic [1:0]          wcnt;
  logic                own;
  logic                last_gnt;
  logic [WORD_W-1:0]   sub_in;
  logic [WORD_W-1:0]   sub_out;
  logic                job_last;

  logic                st_out_valid_nxt;
  logic                kw_out_valid_nxt;
  logic [STATE_W-1:0]  st_out_nxt;
  logic [WORD_W-1:0]   kw_out_nxt;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Word select: key jobs live in the low word, state jobs walk MSW first.
  always_comb begin
    sub_in = work[31:0];
    if (own == OWN_ST) begin
      case (wcnt)
        2'd0:    sub_in = work[127:96];
        2'd1:    sub_in = work[95:64];
        2'd2:    sub_in = work[63:32];
        default: sub_in = work[31:0];
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign sub_out[8*g +: 8] = sbox(sub_in[8*g +: 8]);
  end

  // Substituted word merged back into its slot of the work register.
  always_comb begin
    work_wb = work;
    if (own == OWN_KW) begin
      work_wb[31:0] = sub_out;
    end else begin
      case (wcnt)
        2'd0:    work_wb[127:96] = sub_out;
        2'd1:    work_wb[95:64]  = sub_out;
        2'd2:    work_wb[63:32]  = sub_out;
        default: work_wb[31:0]   = sub_out;
      endcase
    end
  end

  assign job_last = (own == OWN_KW) || (wcnt == 2'd3);

  // Round-robin grant; a tie goes to the requester not served last.
  assign stReady = (state == IDLE) && stValid && (!kwValid || (last_gnt == OWN_KW));
  assign kwReady = (state == IDLE) && kwValid && (!stValid || (last_gnt == OWN_ST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (stReady || kwReady) state_nxt = BUSY;
      BUSY:    if (job_last)           state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers load on the last BUSY cycle so the pulse lands in DONE.
  always_comb begin
    st_out_valid_nxt = 1'b0;
    kw_out_valid_nxt = 1'b0;
    st_out_nxt       = stOut;
    kw_out_nxt       = kwOut;
    if ((state == BUSY) && job_last) begin
      if (own == OWN_KW) begin
        kw_out_nxt       = sub_out;
        kw_out_valid_nxt = 1'b1;
      end else begin
        st_out_nxt       = work_wb;
        st_out_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stOutValid <= 1'b0;
      kwOutValid <= 1'b0;
      stOut      <= '0;
      kwOut      <= '0;
    end else begin
      stOutValid <= st_out_valid_nxt;
      kwOutValid <= kw_out_valid_nxt;
      stOut      <= st_out_nxt;
      kwOut      <= kw_out_nxt;
    end
  end

  // Job capture and word-by-word substitution.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work     <= '0;
      wcnt     <= 2'd0;
      own      <= OWN_ST;
      last_gnt <= OWN_KW;
    end else begin
      if (stReady) begin
        work     <= stIn;
        own      <= OWN_ST;
        last_gnt <= OWN_ST;
        wcnt     <= 2'd0;
      end else if (kwReady) begin
        work     <= {96'd0, kwIn};
        own      <= OWN_KW;
        last_gnt <= OWN_KW;
        wcnt     <= 2'd0;
      end else if (state == BUSY) begin
        work <= work_wb;
        wcnt <= wcnt + 2'd1;
      end
    end
  end

endmodule
